// File: rtl/pipe_hazard_track.sv
// Tracks destination registers of in-flight instructions after decode and resolves
// each decode source by forwarding from the youngest matching stage, or by interlocking.
module pipe_hazard_track #(
  parameter int NSTAGE = 3,
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int NSRC   = 2,
  parameter int CW     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_hold,
  input  logic                   i_flush,
  input  logic                   i_d_valid,
  input  logic [AW-1:0]          i_d_rda,
  input  logic                   i_d_rfwe,
  input  logic [NSRC*AW-1:0]     i_d_srca,
  input  logic [NSRC-1:0]        i_d_src_used,
  input  logic [NSTAGE*DW-1:0]   i_s_data,
  input  logic [NSTAGE-1:0]      i_s_dvalid,
  output logic [NSTAGE-1:0]      o_s_valid,
  output logic [NSTAGE*AW-1:0]   o_s_rda,
  output logic [NSTAGE-1:0]      o_s_rfwe,
  output logic [NSRC-1:0]        o_fwd_hit,
  output logic [NSRC*DW-1:0]     o_fwd_data,
  output logic                   o_stall,
  output logic [CW-1:0]          o_stall_cnt
);

  logic [NSTAGE-1:0]    valid_q, valid_d;
  logic [NSTAGE-1:0]    rfwe_q, rfwe_d;
  logic [NSTAGE*AW-1:0] rda_q, rda_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NSRC-1:0]      pend;
  logic                 load_ok;

  // Per-source lookup: scanning from stage 0 upward, the first match is the youngest producer.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic          found;
      logic          hit_k;
      logic          pend_k;
      logic [DW-1:0] data_k;
      logic [AW-1:0] srca_k;

      assign srca_k = i_d_srca[gi*AW +: AW];

      always_comb begin
        found  = 1'b0;
        hit_k  = 1'b0;
        pend_k = 1'b0;
        data_k = '0;
        for (int s = 0; s < NSTAGE; s++) begin
          if (!found && valid_q[s] && rfwe_q[s] && i_d_src_used[gi] &&
              (rda_q[s*AW +: AW] == srca_k) && (rda_q[s*AW +: AW] != '0)) begin
            found = 1'b1;
            if (i_s_dvalid[s]) begin
              hit_k  = 1'b1;
              data_k = i_s_data[s*DW +: DW];
            end else begin
              pend_k = 1'b1;
            end
          end
        end
      end

      assign o_fwd_hit[gi]             = hit_k;
      assign o_fwd_data[gi*DW +: DW]   = data_k;
      assign pend[gi]                  = pend_k;
    end
  endgenerate

  assign o_stall = (|pend) & i_d_valid & ~i_flush;
  assign load_ok = i_d_valid & ~i_flush & ~o_stall;

  // A stalled or flushed decode enters stage 0 as a bubble so older stages keep draining.
  always_comb begin
    valid_d = valid_q;
    rfwe_d  = rfwe_q;
    rda_d   = rda_q;
    cnt_d   = cnt_q;
    if (!i_hold) begin
      valid_d = {valid_q[NSTAGE-2:0], load_ok};
      rfwe_d  = {rfwe_q[NSTAGE-2:0], load_ok & i_d_rfwe};
      rda_d   = {rda_q[(NSTAGE-1)*AW-1:0], (load_ok ? i_d_rda : {AW{1'b0}})};
      if (o_stall && (cnt_q != {CW{1'b1}})) begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rfwe_q  <= '0;
      rda_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rfwe_q  <= rfwe_d;
      rda_q   <= rda_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_s_valid   = valid_q;
  assign o_s_rfwe    = rfwe_q;
  assign o_s_rda     = rda_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_track.sv
// Scoreboard bench for pipe_hazard_track: expectations are queued as stimulus is applied
// and compared once the design's outputs have settled.
module tb_pipe_hazard_track;
  localparam int NSTAGE = 3;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NSRC   = 2;
  localparam int CW     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hold, flush, d_valid, d_rfwe;
  logic [AW-1:0]        d_rda;
  logic [NSRC*AW-1:0]   srca;
  logic [NSRC-1:0]      src_used;
  logic [NSTAGE*DW-1:0] s_data;
  logic [NSTAGE-1:0]    s_dvalid;
  logic [NSTAGE-1:0]    s_valid, s_rfwe;
  logic [NSTAGE*AW-1:0] s_rda;
  logic [NSRC-1:0]      fwd_hit;
  logic [NSRC*DW-1:0]   fwd_data;
  logic                 stall;
  logic [CW-1:0]        stall_cnt;

  int          ncmp = 0;
  int          nfail = 0;
  string       nq[$];
  logic [63:0] eq[$];
  string       en;
  logic [63:0] ev, got;

  pipe_hazard_track #(.NSTAGE(NSTAGE), .AW(AW), .DW(DW), .NSRC(NSRC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .i_hold(hold), .i_flush(flush), .i_d_valid(d_valid),
    .i_d_rda(d_rda), .i_d_rfwe(d_rfwe), .i_d_srca(srca), .i_d_src_used(src_used),
    .i_s_data(s_data), .i_s_dvalid(s_dvalid), .o_s_valid(s_valid), .o_s_rda(s_rda),
    .o_s_rfwe(s_rfwe), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data), .o_stall(stall),
    .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle;
    hold = 0; flush = 0; d_valid = 0; d_rfwe = 0; d_rda = '0;
    srca = '0; src_used = '0; s_data = '0; s_dvalid = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #7;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b0;
    d_valid = 1; d_rfwe = 1; d_rda = 5'd5; srca = {5'd5, 5'd5}; src_used = 2'b11;
    s_dvalid = 3'b111; s_data = {32'h3, 32'h2, 32'h1};
    nq.push_back("rst_valid"); eq.push_back(64'(3'b000));
    nq.push_back("rst_cnt");   eq.push_back(64'(4'd0));
    #13;
    got = 64'(s_valid); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall_cnt); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    @(posedge clk); #1; rst = 1'b1;
    nq.push_back("empty_hit");   eq.push_back(64'(2'b00));
    nq.push_back("empty_stall"); eq.push_back(64'(1'b0));
    settle();
    got = 64'(fwd_hit); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
  endtask

  task automatic test_forward;
    idle();
    do_reset();
    d_valid = 1; d_rfwe = 1; d_rda = 5'd5;
    tick();
    srca = {5'd5, 5'd5}; src_used = 2'b11; s_dvalid = 3'b001;
    s_data = {32'hDEAD0002, 32'hDEAD0001, 32'h00001234};
    nq.push_back("fwd_hit");   eq.push_back(64'(2'b11));
    nq.push_back("fwd_data");  eq.push_back(64'h00001234_00001234);
    nq.push_back("fwd_stall"); eq.push_back(64'(1'b0));
    nq.push_back("fwd_rda0");  eq.push_back(64'(5'd5));
    settle();
    got = 64'(fwd_hit); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(fwd_data); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(s_rda[4:0]); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
  endtask

  // Continues from test_forward: its x5 writer enters the pipe behind the first one.
  task automatic test_load_stall;
    tick();
    d_rda = 5'd7; srca = {5'd0, 5'd5}; src_used = 2'b01; s_dvalid = 3'b010;
    s_data = {32'h0, 32'h000000AA, 32'h00000055};
    nq.push_back("ld_hit");   eq.push_back(64'(2'b00));
    nq.push_back("ld_data");  eq.push_back(64'h0);
    nq.push_back("ld_stall"); eq.push_back(64'(1'b1));
    settle();
    got = 64'(fwd_hit); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(fwd_data); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    tick();
    s_dvalid = 3'b010; s_data = {32'h0, 32'h000000BB, 32'h00000055};
    nq.push_back("ld_valid"); eq.push_back(64'(3'b110));
    nq.push_back("ld_cnt");   eq.push_back(64'(4'd1));
    nq.push_back("ld_hit2");  eq.push_back(64'(2'b01));
    nq.push_back("ld_data2"); eq.push_back(64'h000000BB);
    nq.push_back("ld_stall2"); eq.push_back(64'(1'b0));
    settle();
    got = 64'(s_valid); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall_cnt); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(fwd_hit); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(fwd_data); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
  endtask

  task automatic test_x0;
    idle();
    do_reset();
    d_valid = 1; d_rfwe = 1; d_rda = 5'd0;
    tick();
    srca = {5'd0, 5'd0}; src_used = 2'b01; s_dvalid = 3'b000;
    nq.push_back("x0_rfwe");  eq.push_back(64'(3'b001));
    nq.push_back("x0_hit");   eq.push_back(64'(2'b00));
    nq.push_back("x0_stall"); eq.push_back(64'(1'b0));
    settle();
    got = 64'(s_rfwe); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(fwd_hit); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
  endtask

  task automatic test_flush_hold;
    idle();
    do_reset();
    d_valid = 1; d_rfwe = 1; d_rda = 5'd5;
    tick();
    d_rda = 5'd9; srca = {5'd0, 5'd5}; src_used = 2'b01; s_dvalid = 3'b000; flush = 1;
    nq.push_back("fl_stall"); eq.push_back(64'(1'b0));
    settle();
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    tick();
    flush = 0; hold = 1;
    nq.push_back("fl_valid");   eq.push_back(64'(3'b010));
    nq.push_back("fl_rda");     eq.push_back(64'h0A0);
    nq.push_back("hold_stall"); eq.push_back(64'(1'b1));
    settle();
    got = 64'(s_valid); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(s_rda); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    nq.push_back("hold_valid"); eq.push_back(64'(3'b010));
    nq.push_back("hold_rda");   eq.push_back(64'h0A0);
    nq.push_back("hold_cnt");   eq.push_back(64'(4'd0));
    for (int i = 0; i < 3; i++) tick();
    settle();
    got = 64'(s_valid); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(s_rda); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall_cnt); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    hold = 0;
    nq.push_back("rel_valid"); eq.push_back(64'(3'b100));
    nq.push_back("rel_cnt");   eq.push_back(64'(4'd1));
    tick();
    settle();
    got = 64'(s_valid); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall_cnt); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
  endtask

  // Each episode: one x5 load, then three stalled edges while it drains unreturned.
  task automatic test_saturate;
    int model = 0;
    idle();
    do_reset();
    for (int ep = 0; ep < 7; ep++) begin
      d_valid = 1; d_rfwe = 1; d_rda = 5'd5; src_used = 2'b00; s_dvalid = 3'b000;
      tick();
      srca = {5'd0, 5'd5}; src_used = 2'b01;
      for (int i = 0; i < 3; i++) begin
        tick();
        model = (model < 15) ? model + 1 : 15;
      end
      if (ep == 3 || ep == 6) begin
        nq.push_back($sformatf("sat_cnt_ep%0d", ep)); eq.push_back(64'(model));
        settle();
        got = 64'(stall_cnt); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
        if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
      end
    end
    src_used = 2'b00;
    tick();
    src_used = 2'b01;
    tick();
    #2;
    rst = 1'b0;
    nq.push_back("arst_valid"); eq.push_back(64'(3'b000));
    nq.push_back("arst_rda");   eq.push_back(64'h0);
    nq.push_back("arst_cnt");   eq.push_back(64'(4'd0));
    nq.push_back("arst_stall"); eq.push_back(64'(1'b0));
    #1;
    got = 64'(s_valid); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(s_rda); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall_cnt); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(stall); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    d_rda = 5'd9;
    #1;
    rst = 1'b1;
    nq.push_back("post_valid"); eq.push_back(64'(3'b001));
    nq.push_back("post_rda");   eq.push_back(64'(15'd9));
    tick();
    settle();
    got = 64'(s_valid); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
    got = 64'(s_rda); en = nq.pop_front(); ev = eq.pop_front(); ncmp++;
    if (got !== ev) begin nfail++; $display("FAIL %s got=%0h exp=%0h", en, got, ev); end else $display("ok   %s = %0h", en, got);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_stall();
    test_x0();
    test_flush_hold();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_track.md
PIPE_HAZARD_TRACK -- requirements
Module: pipe_hazard_track

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, number of tracked post-decode stages (stage 0 = execute, youngest), legal 2..6.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter NSRC, default 2, source operands per instruction, legal 1..3.
REQ-005 SHALL have parameter CW, default 16, stall counter width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 i_hold  in  1  external stall; freezes all stages.
REQ-010 i_flush  in  1  kill the decode instruction (taken jump/branch).
REQ-011 i_d_valid  in  1  decode slot holds a real instruction.
REQ-012 i_d_rda  in  AW  decode destination address.
REQ-013 i_d_rfwe  in  1  decode instruction writes register file.
REQ-014 i_d_srca  in  NSRC*AW  decode source addresses, source k at bits [k*AW +: AW].
REQ-015 i_d_src_used  in  NSRC  source k is actually read.
REQ-016 i_s_data  in  NSTAGE*DW  result per stage, stage s at [s*DW +: DW].
REQ-017 i_s_dvalid  in  NSTAGE  stage s result is final (low for load not yet returned).
REQ-018 o_s_valid / o_s_rda / o_s_rfwe  out  NSTAGE / NSTAGE*AW / NSTAGE  tracked stage contents.
REQ-019 o_fwd_hit  out  NSRC  source k satisfied by forwarding.
REQ-020 o_fwd_data  out  NSRC*DW  forwarded value for source k.
REQ-021 o_stall  out  1  interlock: decode/fetch must hold.
REQ-022 o_stall_cnt  out  CW  saturating count of interlock cycles.

Function
REQ-023 Each stage register SHALL hold valid, rda, rfwe; no data is stored (data comes from i_s_data).
REQ-024 Match for source k at stage s SHALL require o_s_valid[s], o_s_rfwe[s], i_d_src_used[k], rda equal, and rda != 0.
REQ-025 Priority SHALL be youngest first: lowest matching s wins; older matches ignored.
REQ-026 If winning stage has i_s_dvalid[s]=1: o_fwd_hit[k]=1, o_fwd_data[k]=stage s data; else hit=0, data=0, and source k is pending.
REQ-027 No match: hit=0, data=0 (register-file value used).
REQ-028 o_stall SHALL be combinational: any source pending AND i_d_valid AND !i_flush.
REQ-029 Edge with i_hold=1: all stage registers and o_stall_cnt unchanged; i_hold overrides i_flush and o_stall.
REQ-030 Edge with i_hold=0: stage s+1 <= stage s for s = 0..NSTAGE-2; oldest stage retires (one-cycle shift, no skipping).
REQ-031 Stage 0 load with i_hold=0: bubble (valid=0, rfwe=0, rda=0) if i_flush or o_stall or !i_d_valid; else {1, i_d_rda, i_d_rfwe}.
REQ-032 o_stall_cnt SHALL increment by 1 on each edge with o_stall=1 and i_hold=0, saturating at all-ones; never wraps.
REQ-033 Bubble advancement under o_stall SHALL let a pending load reach a stage with dvalid=1, releasing the stall without deadlock.
REQ-034 Simultaneous i_flush and pending source: flush wins, o_stall=0, bubble inserted.

Reset
REQ-035 While rst=0: all o_s_valid, o_s_rfwe, o_s_rda = 0, o_stall_cnt = 0, asynchronously, independent of clk.
REQ-036 With stages invalid after reset, o_fwd_hit=0, o_fwd_data=0, o_stall=0 regardless of decode inputs.
REQ-037 Reset asserted mid-stall SHALL clear state; first edge after release behaves as REQ-030/031 from empty pipeline.

Verification (NSTAGE=3, NSRC=2, AW=5, DW=32)
REQ-038 Decode x5 valid rfwe, next decode srca0=5, stage0 dvalid=1 data 0x1234 -> hit[0]=1, data 0x00001234, o_stall=0.
REQ-039 x5 in stage 0 (dvalid=0) and stage 1 (dvalid=1, 0xAA) -> hit[0]=0, o_stall=1; next edge stage0 bubble, stall_cnt=1; load reaches stage 1 with dvalid=1 -> hit, data from stage 1.
REQ-040 Source x0 with stage 0 rda=0 rfwe=1 -> hit=0, o_stall=0.
REQ-041 Pending source with i_flush=1 -> o_stall=0, stage0 becomes bubble; with i_hold=1 three cycles -> stage contents and stall_cnt unchanged.
REQ-042 Hold o_stall=1 for 2^CW+4 edges -> o_stall_cnt = all-ones; assert rst=0 mid-cycle -> outputs 0 before next edge.
